// File: rtl/decode_out_buffer.sv
// rtl/decode_out_buffer.sv - DEPTH-entry decode-to-execute FIFO with valid/ready, flush and occupancy.
// Optional zero-latency empty-buffer bypass enabled by defining DECODE_OUT_BYPASS_EN.
module decode_out_buffer #(
  parameter int IR_W       = 16,
  parameter int NPC_W      = 16,
  parameter int E_CTRL_W   = 6,
  parameter int MEM_CTRL_W = 1,
  parameter int W_CTRL_W   = 2,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IR_W-1:0]       in_ir,
  input  logic [NPC_W-1:0]      in_npc,
  input  logic [E_CTRL_W-1:0]   in_e_control,
  input  logic [MEM_CTRL_W-1:0] in_mem_control,
  input  logic [W_CTRL_W-1:0]   in_w_control,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IR_W-1:0]       IR,
  output logic [E_CTRL_W-1:0]   E_Control,
  output logic [NPC_W-1:0]      npc_out,
  output logic [MEM_CTRL_W-1:0] Mem_Control,
  output logic [W_CTRL_W-1:0]   W_Control,
  output logic [CNT_W-1:0]      count,
  output logic                  drop_err
);

  localparam int BUN_W = IR_W + NPC_W + E_CTRL_W + MEM_CTRL_W + W_CTRL_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BUN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [BUN_W-1:0] in_bundle;
  logic [BUN_W-1:0] head;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             store;
  logic             retire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_bundle = {in_ir, in_npc, in_e_control, in_mem_control, in_w_control};

  // Ready never looks at out_ready, so a full buffer cannot accept on the pop cycle.
  assign in_ready = (count < FULL_CNT) && !flush && !reset;

`ifdef DECODE_OUT_BYPASS_EN
  assign bypass = (count == '0) && in_valid && !flush && !reset;
  assign head   = bypass ? in_bundle : mem[rd_ptr];
`else
  assign bypass = 1'b0;
  assign head   = mem[rd_ptr];
`endif

  assign out_valid = (count != '0) || bypass;
  assign {IR, npc_out, E_Control, Mem_Control, W_Control} = out_valid ? head : '0;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready && !flush && !reset;
  // A bypassed bundle consumed in the same cycle never touches storage.
  assign store  = push && !(bypass && out_ready);
  assign retire = pop && !bypass;

  always_ff @(posedge clock) begin
    if (store) begin
      mem[wr_ptr] <= in_bundle;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= in_valid;
    end else begin
      drop_err <= 1'b0;
      if (store) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (retire) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({store, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A stalled head must not change under execute.
  assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready && !flush) |=>
      (out_valid && $stable({IR, npc_out, E_Control, Mem_Control, W_Control})));
`endif

endmodule

// File: tb/tb_decode_out_buffer.sv
// tb/tb_decode_out_buffer.sv - Vector table, streaming sequence and randomized queue-model check of decode_out_buffer.
module tb_decode_out_buffer;
  localparam int DEPTH = 2;
`ifdef DECODE_OUT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid, drop_err;
  logic [15:0] in_ir, in_npc, IR, npc_out;
  logic [5:0]  in_e_control, E_Control;
  logic [0:0]  in_mem_control, Mem_Control;
  logic [1:0]  in_w_control, W_Control;
  logic [1:0]  count;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  decode_out_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_npc(in_npc), .in_e_control(in_e_control),
    .in_mem_control(in_mem_control), .in_w_control(in_w_control), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .IR(IR), .E_Control(E_Control),
    .npc_out(npc_out), .Mem_Control(Mem_Control), .W_Control(W_Control),
    .count(count), .drop_err(drop_err)
  );

  typedef struct {
    logic rst, iv, fl, ordy;
    logic [15:0] ir, npc;
    logic [5:0] e;
    logic [1:0] w;
    int cnt;
    logic ov;
    logic [15:0] xir, xnpc;
    logic [5:0] xe;
    logic [1:0] xw;
    logic irdy, derr;
  } vec_t;

  typedef logic [40:0] bun_t;
  bun_t q[$];
  logic m_drop;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic iv, logic fl, logic ordy, logic [15:0] ir,
                              logic [15:0] npc, logic [5:0] e, logic [1:0] w, int cnt,
                              logic ov, logic [15:0] xir, logic [15:0] xnpc, logic [5:0] xe,
                              logic [1:0] xw, logic irdy, logic derr);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ir = ir; v.npc = npc; v.e = e; v.w = w;
    v.cnt = cnt; v.ov = ov; v.xir = xir; v.xnpc = xnpc; v.xe = xe; v.xw = xw;
    v.irdy = irdy; v.derr = derr;
    return v;
  endfunction

  function automatic bun_t cur_in();
    return {in_ir, in_npc, in_e_control, in_mem_control, in_w_control};
  endfunction

  // Expected combinational view from the queue contents and current inputs.
  function automatic void calc(output bit rdy, output bit byp, output bit ov);
    rdy = (q.size() < DEPTH) && (flush !== 1'b1) && (reset !== 1'b1);
    byp = BYP && (q.size() == 0) && (in_valid === 1'b1) && (flush !== 1'b1) && (reset !== 1'b1);
    ov  = (q.size() != 0) || byp;
  endfunction

  task automatic model_check();
    bit rdy, byp, ov;
    bun_t h;
    calc(rdy, byp, ov);
    h = byp ? cur_in() : ((q.size() != 0) ? q[0] : '0);
    chk("rnd in_ready", in_ready, rdy);
    chk("rnd out_valid", out_valid, ov);
    chk("rnd count", count, q.size());
    chk("rnd drop_err", drop_err, m_drop);
    chk("rnd IR", IR, h[40:25]);
    chk("rnd npc_out", npc_out, h[24:9]);
    chk("rnd E_Control", E_Control, h[8:3]);
    chk("rnd Mem_Control", Mem_Control, h[2]);
    chk("rnd W_Control", W_Control, h[1:0]);
  endtask

  task automatic model_update();
    bit rdy, byp, ov;
    calc(rdy, byp, ov);
    if (reset) begin
      q.delete();
      m_drop = 1'b0;
    end else if (flush) begin
      q.delete();
      m_drop = in_valid;
    end else begin
      m_drop = 1'b0;
      if (ov && out_ready && !byp) void'(q.pop_front());
      if (in_valid && rdy && !(byp && out_ready)) q.push_back(cur_in());
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_npc = '0; in_e_control = '0; in_mem_control = '0; in_w_control = '0;
    m_drop = 1'b0;

    //           rst iv fl or  ir        npc       e      w     cnt ov xir       xnpc      xe     xw    rdy derr
    tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 16'h1234, 16'h3001, 6'h2A, 2'd2, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 1, 16'h1234, 16'h3001, 6'h2A, 2'd2, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 1, 16'h1234, 16'h3001, 6'h2A, 2'd2, 1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 16'hA001, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 16'hA002, 16'h0000, 6'h00, 2'd0, 1, 1, 16'hA001, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 1, 16'hA003, 16'h0000, 6'h00, 2'd0, 2, 1, 16'hA001, 16'h0000, 6'h00, 2'd0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 1, 16'hA002, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 16'hA004, 16'h0000, 6'h00, 2'd0, 1, 1, 16'hA002, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 1, 16'hA005, 16'h0000, 6'h00, 2'd0, 2, 1, 16'hA002, 16'h0000, 6'h00, 2'd0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 16'hB001, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 16'hB002, 16'h0000, 6'h00, 2'd0, 1, 1, 16'hB001, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[14] = mk(1, 1, 0, 0, 16'hB003, 16'h0000, 6'h00, 2'd0, 2, 1, 16'hB001, 16'h0000, 6'h00, 2'd0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 16'hBEEF, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[16] = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 1, 16'hBEEF, 16'h0000, 6'h00, 2'd0, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 0, 0, 16'h0000, 16'h0000, 6'h00, 2'd0, 1, 0);

    @(posedge clock);

`ifndef DECODE_OUT_BYPASS_EN
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      reset = tbl[i].rst; in_valid = tbl[i].iv; flush = tbl[i].fl; out_ready = tbl[i].ordy;
      in_ir = tbl[i].ir; in_npc = tbl[i].npc; in_e_control = tbl[i].e;
      in_mem_control = '0; in_w_control = tbl[i].w;
      #2;
      chk($sformatf("row%0d count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("row%0d IR", i), IR, tbl[i].xir);
      chk($sformatf("row%0d npc_out", i), npc_out, tbl[i].xnpc);
      chk($sformatf("row%0d E_Control", i), E_Control, tbl[i].xe);
      chk($sformatf("row%0d W_Control", i), W_Control, tbl[i].xw);
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].irdy);
      chk($sformatf("row%0d drop_err", i), drop_err, tbl[i].derr);
      @(posedge clock);
    end

    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = (k < 8);
      in_ir = 16'(k); in_npc = '0; in_e_control = '0; in_mem_control = '0; in_w_control = '0;
      #2;
      chk($sformatf("stream%0d out_valid", k), out_valid, (k != 0));
      chk($sformatf("stream%0d count", k), count, (k != 0) ? 1 : 0);
      if (k != 0) chk($sformatf("stream%0d IR", k), IR, k - 1);
      @(posedge clock);
    end
`endif

    @(negedge clock);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    q.delete();
    m_drop = 1'b0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      reset          = ($urandom_range(0, 99) < 2);
      flush          = ($urandom_range(0, 99) < 5);
      in_valid       = ($urandom_range(0, 99) < 60);
      out_ready      = ($urandom_range(0, 99) < 50);
      in_ir          = 16'($urandom);
      in_npc         = 16'($urandom);
      in_e_control   = 6'($urandom);
      in_mem_control = 1'($urandom);
      in_w_control   = 2'($urandom);
      #2;
      model_check();
      @(posedge clock);
      model_update();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_out_buffer.md
Name: decode_out_buffer

Overview:
- Parametrised decode-to-execute boundary buffer for the LC-3 style pipeline. Carries the decode output bundle (IR, E_Control, npc_out, Mem_Control, W_Control).
- Generalises the fixed single-stage decode output into a DEPTH-entry FIFO with a valid/ready handshake, flush and occupancy reporting. Execute can stall without back-pressuring decode on the same cycle.
- Sits between the decode stage and the execute stage. Verification drives and monitors it with the decode_out agent.

Parameters:
- IR_W, 16, instruction register width
- NPC_W, 16, next-PC width
- E_CTRL_W, 6, execute control width
- MEM_CTRL_W, 1, memory control width
- W_CTRL_W, 2, writeback control width
- DEPTH, 2, number of entries, legal range 1..16
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents a bundle
- in_ready  output  1  buffer can accept a bundle this cycle
- in_ir  input  IR_W  decoded instruction
- in_npc  input  NPC_W  next PC
- in_e_control  input  E_CTRL_W  execute controls
- in_mem_control  input  MEM_CTRL_W  memory controls
- in_w_control  input  W_CTRL_W  writeback controls
- flush  input  1  discard all buffered bundles (branch/trap redirect)
- out_valid  output  1  head bundle valid
- out_ready  input  1  execute consumes the head bundle
- IR  output  IR_W  head instruction
- E_Control  output  E_CTRL_W  head execute controls
- npc_out  output  NPC_W  head next PC
- Mem_Control  output  MEM_CTRL_W  head memory controls
- W_Control  output  W_CTRL_W  head writeback controls
- count  output  CNT_W  current occupancy
- drop_err  output  1  one-cycle pulse: in_valid asserted during flush

Behaviour:
- Reset (synchronous, active-high, highest priority): all entries invalid; write/read pointers 0; count=0; out_valid=0; bundle outputs=0; drop_err=0. in_ready=0 while reset=1.
- Push: in_valid && in_ready at a clock edge writes the bundle at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
- Pop: out_valid && out_ready at a clock edge retires the head. rd_ptr wraps DEPTH-1 -> 0.
- in_ready = (count < DEPTH) && !flush && !reset.
  - Depends only on registered state, never on out_ready. No combinational ready path.
  - When full, a simultaneous pop does not enable a push in that cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- out_valid = (count != 0).
- Bundle outputs present the head entry when out_valid=1. They are forced to 0 when out_valid=0.
- Data latency: 1 cycle. A bundle pushed at edge N appears on the outputs after edge N when the buffer was empty.
- Ordering: strict FIFO. No reordering, no duplication.
- Flush at an edge:
  - count<=0, pointers<=0, out_valid drops on the next cycle.
  - Any pop in that cycle is ignored.
  - Input is not accepted (in_ready=0).
  - If in_valid=1 during flush, drop_err pulses the next cycle.
- Reset asserted mid-stream: all contents discarded exactly as a flush, with drop_err=0.
- Holding rule: while out_valid=1 and out_ready=0, outputs hold stable. A violation is a design bug and carries an assertion.
- DEPTH=1: behaves as a plain pipeline register with in_ready = !out_valid.

Optional Feature:
- Macro: DECODE_OUT_BYPASS_EN
- Defined: when count==0, in_valid=1 and flush=0, the input bundle is routed combinationally to the outputs with out_valid=1 (zero latency).
  - If out_ready=1 in that cycle, the bundle is consumed and not written.
  - Otherwise it is written and held as head.
  - count reflects only stored entries.
- Not defined: no input-to-output combinational path; 1-cycle latency as above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> count=0, out_valid=0, IR=0, in_ready=0 during reset and 1 after.
- Single push, DEPTH=2: in_ir=16'h1234, in_npc=16'h3001, in_e_control=6'h2A, in_w_control=2'b10, out_ready=0 -> next cycle out_valid=1, IR=16'h1234, npc_out=16'h3001, count=1.
  - With DECODE_OUT_BYPASS_EN: the same values appear in the push cycle itself.
- Fill/back-pressure: push 16'hA001, 16'hA002 with out_ready=0 -> count=2, in_ready=0.
  - Push of 16'hA003 with out_ready=1 that cycle is not accepted; next cycle count=1, IR=16'hA002.
- Streaming: continuous in_valid/out_ready=1 for 8 bundles (IR 0..7) -> outputs IR 0..7 in order, count steady at 1, pointers wrap with no loss.
- Flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, drop_err=1 for exactly one cycle, in_ready=1.
- Reset mid-stream: count=2, assert reset one cycle -> count=0, outputs 0, drop_err=0; a subsequent push of 16'hBEEF emerges as the first output.
